// File: rtl/pong_pkg.sv
// Shared types and constants for the pong FPGA codebase.
// Holds the SPI word width and the SPI master state encoding.
package pong_pkg;

  localparam int SPI_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TAIL
  } spim_state_t;

endpackage

// File: rtl/spi_half_timer.sv
// Loadable down-counter timing SPI phases and inter-frame gaps.
// A phase loaded with N lasts N+1 cycles; expire is high at zero.
module spi_half_timer #(
  parameter int W = 3
) (
  input  logic         vgaclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI master sending one WIDTH-bit word per start pulse to the PIC.
// CPOL=0, MSB first; sdo changes on sck rise, rx samples at end of high.
module spi_frame_master
  import pong_pkg::*;
#(
  parameter int WIDTH    = SPI_WORD_W,
  parameter int HALF_PER = 4,
  parameter int GAP      = 8
) (
  input  logic             vgaclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sck,
  output logic             sdo,
  input  logic             sdi,
  output logic             cs_b
);

  localparam int HW = $clog2(HALF_PER + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int BW = $clog2(WIDTH);

  // LEAD runs one cycle longer than a half period as cs_b setup
  localparam logic [HW-1:0] LEAD_LD  = HW'(HALF_PER);
  localparam logic [HW-1:0] HALF_LD  = HW'(HALF_PER - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spim_state_t      state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BW-1:0]    bit_cnt;
  logic             last_bit;
  logic             half_load;
  logic             half_exp;
  logic [HW-1:0]    half_val;
  logic             gap_load;
  logic             gap_exp;

  always_comb begin
    half_load = 1'b0;
    last_bit  = (bit_cnt == LAST_BIT);
    half_val  = (state == IDLE) ? LEAD_LD : HALF_LD;
    unique case (state)
      IDLE:            half_load = start;
      LEAD, HIGH, LOW: half_load = half_exp;
      default:         half_load = 1'b0;
    endcase
    gap_load = (state == LOW) && half_exp && last_bit;
  end

  spi_half_timer #(
    .W(HW)
  ) u_half (
    .vgaclk  (vgaclk),
    .reset   (reset),
    .load    (half_load),
    .load_val(half_val),
    .expire  (half_exp)
  );

  spi_half_timer #(
    .W(GW)
  ) u_gap (
    .vgaclk  (vgaclk),
    .reset   (reset),
    .load    (gap_load),
    .load_val(GAP_LD),
    .expire  (gap_exp)
  );

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      sdo     <= 1'b0;
      cs_b    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= tx_data;
            cs_b    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= LEAD;
          end
        end
        LEAD: begin
          if (half_exp) begin
            state <= HIGH;
            sck   <= 1'b1;
            sdo   <= tx_sr[WIDTH-1];
            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
          end
        end
        HIGH: begin
          if (half_exp) begin
            state <= LOW;
            sck   <= 1'b0;
            rx_sr <= {rx_sr[WIDTH-2:0], sdi};
          end
        end
        LOW: begin
          if (half_exp) begin
            if (last_bit) begin
              state   <= TAIL;
              cs_b    <= 1'b1;
              sdo     <= 1'b0;
              rx_data <= rx_sr;
              done    <= 1'b1;
            end else begin
              state   <= HIGH;
              bit_cnt <= bit_cnt + BW'(1);
              sck     <= 1'b1;
              sdo     <= tx_sr[WIDTH-1];
              tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
            end
          end
        end
        TAIL: begin
          if (gap_exp) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: offset-based frame model plus directed cases.
// dut0 uses HALF_PER=2/GAP=8, dut1 uses HALF_PER=1/GAP=1.
module tb_spi_frame_master;

  logic        vgaclk;
  logic        reset;
  logic [1:0]  start;
  logic [31:0] tx [2];
  logic [1:0]  busy, done, sck, sdo, cs_b, sdi;
  logic [31:0] rx [2];

  int checks = 0;
  int errors = 0;
  int dcnt [2];
  int rises0 = 0;
  logic [31:0] cap [2];
  logic [31:0] slave;
  logic        slave_ld;
  logic        mode;
  logic        cmp_en;

  bit          m_act [2];
  int          m_n [2];
  logic [31:0] m_tx [2];
  logic [31:0] m_col [2];
  logic [31:0] m_rxd [2];

  spi_frame_master #(.WIDTH(32), .HALF_PER(2), .GAP(8)) dut0 (
    .vgaclk(vgaclk), .reset(reset), .start(start[0]), .tx_data(tx[0]),
    .busy(busy[0]), .done(done[0]), .rx_data(rx[0]), .sck(sck[0]),
    .sdo(sdo[0]), .sdi(sdi[0]), .cs_b(cs_b[0])
  );

  spi_frame_master #(.WIDTH(32), .HALF_PER(1), .GAP(1)) dut1 (
    .vgaclk(vgaclk), .reset(reset), .start(start[1]), .tx_data(tx[1]),
    .busy(busy[1]), .done(done[1]), .rx_data(rx[1]), .sck(sck[1]),
    .sdo(sdo[1]), .sdi(sdi[1]), .cs_b(cs_b[1])
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  assign sdi[0] = cs_b[0] ? 1'bx : (mode ? slave[31] : sdo[0]);
  assign sdi[1] = sdo[1];

  function automatic int hh(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int gg(input int d);
    return (d == 0) ? 8 : 1;
  endfunction
  function automatic int tt(input int d);
    return (2 * 32 + 1) * hh(d) + 1;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h t=%0t", nm, d, got, want, $time);
    end
  endtask

  // Peer: shifts its word out and captures sdo on every sck fall
  always @(negedge sck[0] or posedge slave_ld) begin
    if (slave_ld) slave <= 32'hDEAD_BEEF;
    else slave <= {slave[30:0], sdo[0]};
  end

  always @(posedge sck[0]) rises0 <= rises0 + 1;
  always @(negedge sck[0]) cap[0] <= {cap[0][30:0], sdo[0]};
  always @(negedge sck[1]) cap[1] <= {cap[1][30:0], sdo[1]};

  // Model: offset n counts vgaclk edges since the accepting edge
  always @(posedge vgaclk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d] <= 1'b0;
        m_n[d]   <= 0;
        m_rxd[d] <= '0;
      end else if (m_act[d]) begin
        m_n[d] <= m_n[d] + 1;
        if (m_n[d] + 1 == tt(d)) m_rxd[d] <= m_col[d];
        if (m_n[d] + 1 == tt(d) + gg(d)) m_act[d] <= 1'b0;
      end else if (start[d]) begin
        m_act[d] <= 1'b1;
        m_n[d]   <= 0;
        m_tx[d]  <= tx[d];
      end
    end
  end

  always @(negedge vgaclk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        int h, n, k, t, bi;
        logic inh, e_sck, e_sdo, e_cs, e_done;
        h = hh(d);
        t = tt(d);
        n = m_n[d];
        inh = m_act[d] && (n >= h + 1) && (n < t);
        k = n - h - 1;
        bi = inh ? 31 - k / (2 * h) : 0;
        e_sck = inh && ((k / h) % 2 == 0);
        e_sdo = inh ? m_tx[d][bi] : 1'b0;
        e_cs = !(m_act[d] && n < t);
        e_done = m_act[d] && (n == t);
        chk("busy", d, 32'(busy[d]), 32'(m_act[d]));
        chk("cs_b", d, 32'(cs_b[d]), 32'(e_cs));
        chk("done", d, 32'(done[d]), 32'(e_done));
        chk("sck", d, 32'(sck[d]), 32'(e_sck));
        chk("sdo", d, 32'(sdo[d]), 32'(e_sdo));
        chk("rx_data", d, rx[d], m_rxd[d]);
        if (done[d] === 1'b1) dcnt[d] <= dcnt[d] + 1;
        if (!m_act[d]) m_col[d] <= '0;
        else if (inh && (k % (2 * h) == h - 1))
          m_col[d] <= {m_col[d][30:0], sdi[d]};
      end
    end
  end

  task automatic wait_idle(input int d);
    int c;
    c = 0;
    while (busy[d] !== 1'b0 && c < 2000) begin
      @(posedge vgaclk);
      #1;
      c++;
    end
    if (c >= 2000) chk("idle_timeout", d, 32'(busy[d]), 32'd0);
    @(posedge vgaclk);
    #1;
  endtask

  // Pulse start, scribble tx_data after acceptance, count to done
  task automatic frame(input int d, input logic [31:0] w, output int lat);
    @(posedge vgaclk);
    #1;
    start[d] = 1'b1;
    tx[d] = w;
    @(posedge vgaclk);
    #1;
    start[d] = 1'b0;
    tx[d] = ~w;
    lat = 0;
    while (done[d] !== 1'b1 && lat < 1000) begin
      @(posedge vgaclk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, base, r0, run, nruns, c;
    bit seen;
    reset = 1'b0;
    start = '0;
    tx[0] = '0;
    tx[1] = '0;
    mode = 1'b0;
    slave_ld = 1'b0;
    cmp_en = 1'b0;
    dcnt[0] = 0;
    dcnt[1] = 0;
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    #20 reset = 1'b0;
    @(posedge vgaclk);
    #1;
    chk("rst_sck", 0, 32'(sck[0]), 32'd0);
    chk("rst_cs_b", 0, 32'(cs_b[0]), 32'd1);
    chk("rst_sdo", 0, 32'(sdo[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_rx", 0, rx[0], 32'd0);

    // 1: loopback
    r0 = rises0;
    frame(0, 32'hA5C3_0F01, lat);
    chk("t1_latency", 0, 32'(lat), 32'd131);
    chk("t1_rises", 0, 32'(rises0 - r0), 32'd32);
    chk("t1_sdo_seq", 0, cap[0], 32'hA5C3_0F01);
    chk("t1_rx", 0, rx[0], 32'hA5C3_0F01);
    wait_idle(0);

    // 2: peer preloaded with DEADBEEF
    mode = 1'b1;
    slave_ld = 1'b1;
    #1 slave_ld = 1'b0;
    frame(0, 32'h1234_5678, lat);
    chk("t2_latency", 0, 32'(lat), 32'd131);
    chk("t2_rx", 0, rx[0], 32'hDEAD_BEEF);
    chk("t2_peer_rx", 0, slave, 32'h1234_5678);
    wait_idle(0);
    mode = 1'b0;

    // 3: start held high for 400 cycles
    base = dcnt[0];
    run = 0;
    nruns = 0;
    seen = 1'b0;
    @(posedge vgaclk);
    #1;
    start[0] = 1'b1;
    tx[0] = 32'h600D_F00D;
    for (int i = 0; i < 400; i++) begin
      @(negedge vgaclk);
      if (cs_b[0]) run++;
      else begin
        if (seen && run > 0) begin
          chk("t3_gap_len", 0, 32'(run), 32'd9);
          nruns++;
        end
        seen = 1'b1;
        run = 0;
      end
    end
    @(posedge vgaclk);
    #1;
    start[0] = 1'b0;
    wait_idle(0);
    chk("t3_gaps", 0, 32'(nruns), 32'd2);
    chk("t3_dones", 0, 32'(dcnt[0] - base), 32'd3);
    chk("t3_rx", 0, rx[0], 32'h600D_F00D);

    // 4: starts during a frame and in the done cycle are dropped
    base = dcnt[0];
    @(posedge vgaclk);
    #1;
    start[0] = 1'b1;
    tx[0] = 32'h0F0F_A0A0;
    @(posedge vgaclk);
    #1;
    start[0] = 1'b0;
    repeat (49) @(posedge vgaclk);
    #1;
    start[0] = 1'b1;
    @(posedge vgaclk);
    #1;
    start[0] = 1'b0;
    repeat (49) @(posedge vgaclk);
    #1;
    chk("t4_rx_hold", 0, rx[0], 32'h600D_F00D);
    c = 0;
    while (done[0] !== 1'b1 && c < 300) begin
      @(posedge vgaclk);
      #1;
      c++;
    end
    chk("t4_done_seen", 0, 32'(done[0]), 32'd1);
    start[0] = 1'b1;
    @(posedge vgaclk);
    #1;
    start[0] = 1'b0;
    chk("t4_rx", 0, rx[0], 32'h0F0F_A0A0);
    wait_idle(0);
    repeat (20) @(posedge vgaclk);
    #1;
    chk("t4_dones", 0, 32'(dcnt[0] - base), 32'd1);
    chk("t4_no_queue", 0, 32'(busy[0]), 32'd0);

    // 5: asynchronous reset mid-frame
    base = dcnt[0];
    @(posedge vgaclk);
    #1;
    start[0] = 1'b1;
    tx[0] = 32'h1357_9BDF;
    @(posedge vgaclk);
    #1;
    start[0] = 1'b0;
    repeat (69) @(posedge vgaclk);
    @(negedge vgaclk);
    #2 reset = 1'b1;
    #1;
    chk("t5_sck", 0, 32'(sck[0]), 32'd0);
    chk("t5_cs_b", 0, 32'(cs_b[0]), 32'd1);
    chk("t5_sdo", 0, 32'(sdo[0]), 32'd0);
    chk("t5_busy", 0, 32'(busy[0]), 32'd0);
    chk("t5_done", 0, 32'(done[0]), 32'd0);
    chk("t5_rx", 0, rx[0], 32'd0);
    @(negedge vgaclk);
    #2 reset = 1'b0;
    chk("t5_no_done", 0, 32'(dcnt[0] - base), 32'd0);
    frame(0, 32'h2468_ACE0, lat);
    chk("t5_latency", 0, 32'(lat), 32'd131);
    chk("t5_rx_clean", 0, rx[0], 32'h2468_ACE0);
    wait_idle(0);

    // 6: fastest sck, minimum gap
    frame(1, 32'hFFFF_0000, lat);
    chk("t6_latency", 1, 32'(lat), 32'd66);
    chk("t6_sdo_seq", 1, cap[1], 32'hFFFF_0000);
    chk("t6_rx", 1, rx[1], 32'hFFFF_0000);
    wait_idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
